// File: rtl/meduram_pkg.sv
// +-----------------------------------------------------------------+
// | meduram_pkg : shared sizing helpers for the multi-bank RAM       |
// | rev 1.0                                                          |
// +-----------------------------------------------------------------+
`default_nettype none

package meduram_pkg;

  localparam int OUT_DEPTH_MIN = 2;
  localparam int OUT_DEPTH_MAX = 16;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic int bank_w(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/meduram_rsp_fifo.sv
// +-----------------------------------------------------------------+
// | meduram_rsp_fifo : sync FIFO with registered head output         |
// | rev 1.0                                                          |
// +-----------------------------------------------------------------+
`default_nettype none

module meduram_rsp_fifo
  import meduram_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] used_q, used_d;
  logic             head_valid_q, head_valid_d;
  logic [WIDTH-1:0] head_data_q, head_data_d;
  logic             take_head;
  logic             mem_we;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Head register refills from storage first; an empty FIFO lets a push bypass straight into it.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    used_d       = used_q;
    head_valid_d = head_valid_q;
    head_data_d  = head_data_q;
    mem_we       = 1'b0;
    take_head    = !head_valid_q || pop;
    if (take_head) begin
      if (used_q != '0) begin
        head_valid_d = 1'b1;
        head_data_d  = mem_q[rd_ptr_q];
        rd_ptr_d     = ptr_inc(rd_ptr_q);
        used_d       = used_q - CNT_W'(1);
      end else if (push) begin
        head_valid_d = 1'b1;
        head_data_d  = push_data;
      end else begin
        head_valid_d = 1'b0;
      end
    end
    if (push && !(take_head && used_q == '0)) begin
      mem_we   = 1'b1;
      wr_ptr_d = ptr_inc(wr_ptr_q);
      used_d   = used_d + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      used_q       <= '0;
      head_valid_q <= 1'b0;
      head_data_q  <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      used_q       <= used_d;
      head_valid_q <= head_valid_d;
      head_data_q  <= head_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_ptr_q] <= push_data;
  end

  assign out_valid = head_valid_q;
  assign out_data  = head_data_q;

endmodule

`default_nettype wire

// File: rtl/bram_read_agent.sv
// +-----------------------------------------------------------------+
// | bram_read_agent : per-port read agent, LVT bank select, buffered |
// | responses. Option macro: MEDURAM_LVT_CHECK_EN (rsp_err, sticky)  |
// | rev 1.0                                                          |
// +-----------------------------------------------------------------+
`default_nettype none

module bram_read_agent
  import meduram_pkg::*;
#(
  parameter int NB_WRAGENT = 2,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int OUT_DEPTH  = 4
) (
  input  logic                             rdclk,
  input  logic                             rdrst_n,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [ADDR_WIDTH-1:0]            req_addr,
  output logic [NB_WRAGENT-1:0]            bank_rden,
  output logic [ADDR_WIDTH*NB_WRAGENT-1:0] bank_rdaddr,
  input  logic [DATA_WIDTH*NB_WRAGENT-1:0] bank_rddata,
  output logic                             lvt_rden,
  output logic [ADDR_WIDTH-1:0]            lvt_rdaddr,
  input  logic [bank_w(NB_WRAGENT)-1:0]    lvt_bank,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [DATA_WIDTH-1:0]            rsp_data
`ifdef MEDURAM_LVT_CHECK_EN
  ,
  output logic                             rsp_err,
  output logic                             lvt_err_sticky
`endif
);

  localparam int CNT_W = clog2(OUT_DEPTH + 1);
`ifdef MEDURAM_LVT_CHECK_EN
  localparam int ENTRY_W = DATA_WIDTH + 1;
`else
  localparam int ENTRY_W = DATA_WIDTH;
`endif

  if (OUT_DEPTH < OUT_DEPTH_MIN || OUT_DEPTH > OUT_DEPTH_MAX) begin : g_depth_range_chk
    $error("bram_read_agent: OUT_DEPTH out of range");
  end

  logic                  accept;
  logic                  pop;
  logic                  head_valid;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [ENTRY_W-1:0]    push_entry;
  logic [ENTRY_W-1:0]    head_entry;
  logic                  s1_valid_q, s1_valid_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  req_ready_q, req_ready_d;

  assign accept    = req_valid & req_ready_q;
  assign pop       = head_valid & rsp_ready;
  assign req_ready = req_ready_q;

  always_comb begin
    bank_rden   = {NB_WRAGENT{accept}};
    bank_rdaddr = {NB_WRAGENT{req_addr}};
    lvt_rden    = accept;
    lvt_rdaddr  = req_addr;
  end

  // Out-of-range LVT indices fall through to lane 0.
  always_comb begin
    sel_data = bank_rddata[0 +: DATA_WIDTH];
    for (int i = 1; i < NB_WRAGENT; i++) begin
      if (32'(lvt_bank) == 32'(i)) sel_data = bank_rddata[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // The credit count covers s1 plus FIFO contents, so neither can overflow.
  always_comb begin
    s1_valid_d = accept;
    unique case ({accept, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
    req_ready_d = (cnt_d < CNT_W'(OUT_DEPTH));
  end

  always_ff @(posedge rdclk or negedge rdrst_n) begin
    if (!rdrst_n) begin
      s1_valid_q  <= 1'b0;
      cnt_q       <= '0;
      req_ready_q <= 1'b1;
    end else begin
      s1_valid_q  <= s1_valid_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
    end
  end

`ifdef MEDURAM_LVT_CHECK_EN
  logic lvt_oob;
  logic lvt_err_sticky_q, lvt_err_sticky_d;

  assign lvt_oob    = (32'(lvt_bank) >= 32'(NB_WRAGENT));
  assign push_entry = {lvt_oob, sel_data};

  always_comb begin
    lvt_err_sticky_d = lvt_err_sticky_q | (s1_valid_q & lvt_oob);
  end

  always_ff @(posedge rdclk or negedge rdrst_n) begin
    if (!rdrst_n) lvt_err_sticky_q <= 1'b0;
    else          lvt_err_sticky_q <= lvt_err_sticky_d;
  end

  assign rsp_err        = head_entry[DATA_WIDTH];
  assign lvt_err_sticky = lvt_err_sticky_q;
`else
  assign push_entry = sel_data;
`endif

  meduram_rsp_fifo #(
    .DEPTH (OUT_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_rsp_fifo (
    .clk       (rdclk),
    .rst_n     (rdrst_n),
    .push      (s1_valid_q),
    .push_data (push_entry),
    .pop       (pop),
    .out_valid (head_valid),
    .out_data  (head_entry)
  );

  assign rsp_valid = head_valid;
  assign rsp_data  = head_entry[DATA_WIDTH-1:0];

endmodule

`default_nettype wire

// File: tb/tb_bram_read_agent.sv
// +-----------------------------------------------------------------+
// | tb_bram_read_agent : scoreboard bench with BRAM/LVT memory model |
// | rev 1.0                                                          |
// +-----------------------------------------------------------------+
`default_nettype none

module tb_bram_read_agent;
  import meduram_pkg::*;

  localparam int NB = 3;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int OD = 4;
  localparam int BW = bank_w(NB);

  logic              rdclk = 1'b0;
  logic              rdrst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [AW-1:0]     req_addr = '0;
  logic [NB-1:0]     bank_rden;
  logic [AW*NB-1:0]  bank_rdaddr;
  logic [DW*NB-1:0]  bank_rddata = '0;
  logic              lvt_rden;
  logic [AW-1:0]     lvt_rdaddr;
  logic [BW-1:0]     lvt_bank = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [DW-1:0]     rsp_data;
`ifdef MEDURAM_LVT_CHECK_EN
  logic              rsp_err;
  logic              lvt_err_sticky;
`endif

  always #5 rdclk = ~rdclk;

  bram_read_agent #(
    .NB_WRAGENT (NB),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .OUT_DEPTH  (OD)
  ) dut (
    .rdclk       (rdclk),
    .rdrst_n     (rdrst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .bank_rden   (bank_rden),
    .bank_rdaddr (bank_rdaddr),
    .bank_rddata (bank_rddata),
    .lvt_rden    (lvt_rden),
    .lvt_rdaddr  (lvt_rdaddr),
    .lvt_bank    (lvt_bank),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data)
`ifdef MEDURAM_LVT_CHECK_EN
    ,
    .rsp_err        (rsp_err),
    .lvt_err_sticky (lvt_err_sticky)
`endif
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
    int            cyc;
    bit            lat;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] bank_mem [NB][256];
  int            lvt_mem  [256];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            n_acc = 0;

  always @(posedge rdclk) cyc <= cyc + 1;

  // Memory model: banks and LVT return data one cycle after their enable.
  always @(posedge rdclk) begin
    for (int i = 0; i < NB; i++)
      if (bank_rden[i]) bank_rddata[i*DW +: DW] <= bank_mem[i][bank_rdaddr[i*AW +: AW]];
    if (lvt_rden) lvt_bank <= BW'(lvt_mem[lvt_rdaddr]);
  end

  function automatic exp_t ref_read(input logic [AW-1:0] a);
    exp_t e;
    int   lane;
    lane   = lvt_mem[a];
    e.err  = (lane >= NB);
    e.data = (lane < NB) ? bank_mem[lane][a] : bank_mem[0][a];
    e.cyc  = 0;
    e.lat  = 1'b0;
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input bit v, input logic [AW-1:0] a, input bit r, input bit lat);
    exp_t e;
    req_valid = v;
    req_addr  = a;
    rsp_ready = r;
    @(negedge rdclk);
    if (v && req_ready) begin
      check("bank_rden", 64'(bank_rden), 64'({NB{1'b1}}));
      check("bank_rdaddr", 64'(bank_rdaddr), 64'({NB{a}}));
      check("lvt_rden", 64'(lvt_rden), 64'd1);
      check("lvt_rdaddr", 64'(lvt_rdaddr), 64'(a));
      e     = ref_read(a);
      e.cyc = cyc;
      e.lat = lat;
      exp_q.push_back(e);
      n_acc++;
    end else begin
      check("bank_rden_idle", 64'(bank_rden), 64'd0);
      check("lvt_rden_idle", 64'(lvt_rden), 64'd0);
    end
    @(posedge rdclk);
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && exp_q.size() > 0; k++) step(1'b0, '0, 1'b1, 1'b0);
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // Scoreboard monitor: pops on every handshake and checks hold under backpressure.
  logic          pv = 1'b0;
  logic          pr = 1'b0;
  logic [DW-1:0] pd = '0;
  exp_t          me;

  always @(negedge rdclk) begin
    if (!rdrst_n) begin
      pv = 1'b0;
    end else begin
      if (pv && !pr) check("rsp_hold", 64'({rsp_valid, rsp_data}), 64'({1'b1, pd}));
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got data 0x%0h, expected no response", rsp_data);
        end else begin
          me = exp_q.pop_front();
          check("rsp_data", 64'(rsp_data), 64'(me.data));
`ifdef MEDURAM_LVT_CHECK_EN
          check("rsp_err", 64'(rsp_err), 64'(me.err));
`endif
          if (me.lat) check("rsp_latency", 64'(cyc - me.cyc), 64'd2);
        end
      end
      pv = rsp_valid;
      pr = rsp_ready;
      pd = rsp_data;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NB; i++)
      for (int a = 0; a < 256; a++) bank_mem[i][a] = $urandom;
    for (int a = 0; a < 256; a++) lvt_mem[a] = $urandom_range(0, 3);
    for (int a = 0; a < 8; a++) lvt_mem[a] = a % NB;
    bank_mem[1][8'h10] = 32'hCAFE0001;
    lvt_mem[8'h10]     = 1;
    bank_mem[0][8'h20] = 32'h0BAD0020;
    lvt_mem[8'h20]     = 3;

    // Reset values
    repeat (3) @(posedge rdclk);
    #1;
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_data", 64'(rsp_data), 64'd0);
    check("rst_bank_rden", 64'(bank_rden), 64'd0);
    check("rst_lvt_rden", 64'(lvt_rden), 64'd0);
    rdrst_n = 1'b1;
    @(posedge rdclk);
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd1);
`ifdef MEDURAM_LVT_CHECK_EN
    check("rst_sticky", 64'(lvt_err_sticky), 64'd0);
`endif

    // Single read with latency check
    step(1'b1, 8'h10, 1'b1, 1'b1);
    drain();

    // Streaming, 8 back-to-back with constant req_ready
    for (int i = 0; i < 8; i++) begin
      check("stream_ready", 64'(req_ready), 64'd1);
      step(1'b1, AW'(i), 1'b1, 1'b1);
    end
    drain();
`ifdef MEDURAM_LVT_CHECK_EN
    check("sticky_clear", 64'(lvt_err_sticky), 64'd0);
`endif

    // LVT index out of range falls back to lane 0
    step(1'b1, 8'h20, 1'b1, 1'b1);
    drain();
`ifdef MEDURAM_LVT_CHECK_EN
    check("sticky_set", 64'(lvt_err_sticky), 64'd1);
`endif

    // Backpressure: exactly OD accepts, then release
    n_acc = 0;
    repeat (8) step(1'b1, AW'($urandom), 1'b0, 1'b0);
    check("bp_accepts", 64'(n_acc), 64'(OD));
    check("bp_ready_low", 64'(req_ready), 64'd0);
    step(1'b0, '0, 1'b1, 1'b0);
    check("bp_ready_after_pop", 64'(req_ready), 64'd1);
    drain();

    // Pop and accept together at cnt = OD-1
    repeat (3) step(1'b1, AW'($urandom), 1'b0, 1'b0);
    repeat (2) step(1'b0, '0, 1'b0, 1'b0);
    check("ovl_head_valid", 64'(rsp_valid), 64'd1);
    step(1'b1, AW'($urandom), 1'b1, 1'b0);
    check("ovl_ready", 64'(req_ready), 64'd1);
    step(1'b0, '0, 1'b0, 1'b0);
    check("ovl_ready_hold", 64'(req_ready), 64'd1);
    step(1'b1, AW'($urandom), 1'b0, 1'b0);
    check("ovl_full", 64'(req_ready), 64'd0);
    drain();

    // Randomized traffic
    repeat (400) step(1'($urandom_range(0, 1)), AW'($urandom), ($urandom_range(0, 3) != 0), 1'b0);
    drain();

    // Reset mid-flight drops everything
    repeat (3) step(1'b1, AW'($urandom), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    rdrst_n = 1'b0;
    #1;
    check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    exp_q.delete();
    @(posedge rdclk);
    #1;
    rdrst_n = 1'b1;
    check("midrst_req_ready", 64'(req_ready), 64'd1);
`ifdef MEDURAM_LVT_CHECK_EN
    check("midrst_sticky", 64'(lvt_err_sticky), 64'd0);
`endif
    repeat (6) step(1'b0, '0, 1'b1, 1'b0);
    check("midrst_no_stale", 64'(rsp_valid), 64'd0);
    step(1'b1, 8'h05, 1'b1, 1'b1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
